iir_pole_ctrl: RTL and testbench

Controller for the 7-tap IIR pole (feedback) section. It accepts coefficient writes into a shadow bank and swaps them atomically into the active bank that drives the multiplier B inputs. Swaps happen only at a sample boundary. It also generates the delay-line advance/clear strobes and aligns an output-valid flag to the registered multiplier latency. It sits between the PYNQ-side configuration bus and the pole datapath.

---
 rtl/iir_pkg.sv | 17 +
 rtl/iir_valid_pipe.sv | 37 +++
 rtl/iir_pole_ctrl.sv | 177 +++++++++++++++++
 tb/tb_iir_pole_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared state encoding, default sizes and coefficient type for the IIR pole-section controller.
package iir_pkg;

  localparam int NUM_TAPS_DEF = 7;
  localparam int COEF_W_DEF   = 16;

  typedef logic signed [COEF_W_DEF-1:0] coef_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SWAP,
    FLUSH,
    DRAIN
  } state_e;

endpackage

// File: rtl/iir_valid_pipe.sv
// Valid-alignment shift register with synchronous clear.
// Latency: DEPTH cycles from d to q.
// Backpressure: none; clr discards everything in flight.
import iir_pkg::*;

module iir_valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = d;
    if (clr) begin
      sr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/iir_pole_ctrl.sv
// Shadow/active coefficient banks for the IIR pole section, swapped at a sample gap; optional flush via IIR_POLE_CTRL_FLUSH_ON_SWAP_EN.
// Latency: coef_o updates 2 cycles after commit (idle slot permitting); out_valid trails filt_ce by MULT_LAT+1.
// Backpressure: cfg_ready low only while a swap waits; samples are never stalled, only dropped when gated.
import iir_pkg::*;

module iir_pole_ctrl #(
  parameter int NUM_TAPS  = NUM_TAPS_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int MULT_LAT  = 3,
  parameter int FLUSH_CYC = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [2:0]                 cfg_addr,
  input  logic [31:0]                cfg_data,
  input  logic                       cfg_commit,
  input  logic                       smp_valid_in,
  output logic [NUM_TAPS*COEF_W-1:0] coef_o,
  output logic                       filt_ce,
  output logic                       filt_clr,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       cfg_err
);

  localparam int BANK_W = NUM_TAPS * COEF_W;

  state_e              state_q, state_d;
  logic [BANK_W-1:0]   shadow_q, shadow_d;
  logic [BANK_W-1:0]   active_q, active_d;
  logic                cfg_err_q, cfg_err_d;
  logic                wr_acc;
  logic                addr_ok;
  logic                swap_now;
  logic                pipe_clr;
  logic                unused_cfg_hi;

`ifdef IIR_POLE_CTRL_FLUSH_ON_SWAP_EN
  localparam int CNT_MAX = (FLUSH_CYC > MULT_LAT) ? FLUSH_CYC : MULT_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  assign unused_cfg_hi = ^cfg_data[31:COEF_W];
  assign wr_acc        = cfg_valid && cfg_ready;
  assign addr_ok       = int'(cfg_addr) < NUM_TAPS;
  // Swap only in a cycle with no sample, so no sample ever straddles two banks.
  assign swap_now      = (state_q == SWAP) && !smp_valid_in;

  always_comb begin
    shadow_d  = shadow_q;
    cfg_err_d = cfg_err_q;
    if (wr_acc) begin
      if (addr_ok) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          if (int'(cfg_addr) == k) begin
            shadow_d[k*COEF_W +: COEF_W] = cfg_data[COEF_W-1:0];
          end
        end
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    active_d = active_q;
    if (swap_now) begin
      active_d = shadow_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b1;
    filt_ce   = 1'b0;
    filt_clr  = 1'b0;
`ifdef IIR_POLE_CTRL_FLUSH_ON_SWAP_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cfg_commit) begin
          state_d = SWAP;
        end
      end
      RUN: begin
        filt_ce = smp_valid_in;
        if (cfg_commit) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        cfg_ready = 1'b0;
        filt_ce   = smp_valid_in;
        if (!smp_valid_in) begin
`ifdef IIR_POLE_CTRL_FLUSH_ON_SWAP_EN
          state_d = FLUSH;
          cnt_d   = '0;
`else
          state_d = RUN;
`endif
        end
      end
`ifdef IIR_POLE_CTRL_FLUSH_ON_SWAP_EN
      FLUSH: begin
        filt_clr = 1'b1;
        if (cnt_q == CNT_W'(FLUSH_CYC - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Let the multiplier pipeline empty before new samples are admitted.
      DRAIN: begin
        if (cnt_q == CNT_W'(MULT_LAT - 1)) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef IIR_POLE_CTRL_FLUSH_ON_SWAP_EN
  assign pipe_clr = swap_now;
`else
  assign pipe_clr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      active_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef IIR_POLE_CTRL_FLUSH_ON_SWAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // One delay-line register plus the multiplier pipeline.
  iir_valid_pipe #(
    .DEPTH (MULT_LAT + 1)
  ) u_valid_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pipe_clr),
    .d     (filt_ce),
    .q     (out_valid)
  );

  assign coef_o  = active_q;
  assign cfg_err = cfg_err_q;
  assign busy    = (state_q != RUN);

endmodule

// File: tb/tb_iir_pole_ctrl.sv
// Randomised self-checking bench for iir_pole_ctrl against a sample-level reference model.
import iir_pkg::*;

module tb_iir_pole_ctrl;

  localparam int NT = 7;
  localparam int CW = 16;
  localparam int ML = 3;
  localparam int FC = 7;
`ifdef IIR_POLE_CTRL_FLUSH_ON_SWAP_EN
  localparam int RESUME = 2 + FC + ML;
`else
  localparam int RESUME = 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [2:0]      cfg_addr = '0;
  logic [31:0]     cfg_data = '0;
  logic            cfg_commit = 1'b0;
  logic            smp_valid_in = 1'b0;
  logic [NT*CW-1:0] coef_o;
  logic            filt_ce;
  logic            filt_clr;
  logic            out_valid;
  logic            busy;
  logic            cfg_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iir_pole_ctrl #(
    .NUM_TAPS  (NT),
    .COEF_W    (CW),
    .MULT_LAT  (ML),
    .FLUSH_CYC (FC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_commit   (cfg_commit),
    .smp_valid_in (smp_valid_in),
    .coef_o       (coef_o),
    .filt_ce      (filt_ce),
    .filt_clr     (filt_clr),
    .out_valid    (out_valid),
    .busy         (busy),
    .cfg_err      (cfg_err)
  );

  // Reference model: phase plus a single countdown covering the whole post-swap pause.
  typedef enum int {M_IDLE, M_RUN, M_SWAP, M_PAUSE} mphase_e;
  mphase_e m_phase;
  int      m_pause;
  coef_t   m_shadow[NT];
  coef_t   m_active[NT];
  bit      m_err;
  bit      ce_hist[0:8191];
  int      m_cyc = 0;
  int      m_last_clr = 0;
  logic [5:0]       exp_f;
  logic [NT*CW-1:0] exp_coef;
  logic [NT*CW-1:0] gold1, gold2;
  int vals[NT] = '{923, -1651, 2047, -1434, 715, -216, 40};

  function automatic logic [5:0] obs_f();
    return {filt_ce, filt_clr, out_valid, busy, cfg_ready, cfg_err};
  endfunction

  function automatic void model_reset();
    m_phase = M_IDLE;
    m_pause = 0;
    m_err   = 1'b0;
    for (int k = 0; k < NT; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_last_clr = m_cyc;
  endfunction

  function automatic void model_eval();
    bit ce, clr, ov;
    int idx;
    ce = (m_phase == M_RUN || m_phase == M_SWAP) && smp_valid_in;
`ifdef IIR_POLE_CTRL_FLUSH_ON_SWAP_EN
    clr = (m_phase == M_PAUSE) && (m_pause > ML);
`else
    clr = 1'b0;
`endif
    idx = m_cyc - ML - 1;
    ov  = (idx >= 0) && (idx > m_last_clr) && ce_hist[idx];
    exp_f = {ce, clr, ov, m_phase != M_RUN, m_phase != M_SWAP, m_err};
    for (int k = 0; k < NT; k++) exp_coef[k*CW +: CW] = m_active[k];
  endfunction

  function automatic void model_adv();
    model_eval();
    ce_hist[m_cyc] = exp_f[5];
    if (cfg_valid && m_phase != M_SWAP) begin
      if (cfg_addr < NT) m_shadow[cfg_addr] = cfg_data[CW-1:0];
      else m_err = 1'b1;
    end
    case (m_phase)
      M_IDLE, M_RUN: if (cfg_commit) m_phase = M_SWAP;
      M_SWAP: begin
        if (!smp_valid_in) begin
          m_active = m_shadow;
`ifdef IIR_POLE_CTRL_FLUSH_ON_SWAP_EN
          m_phase    = M_PAUSE;
          m_pause    = FC + ML;
          m_last_clr = m_cyc;
`else
          m_phase = M_RUN;
`endif
        end
      end
      default: begin
        m_pause--;
        if (m_pause == 0) m_phase = M_RUN;
      end
    endcase
    m_cyc++;
  endfunction

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0; cfg_commit = 1'b0; smp_valid_in = 1'b0;
    cfg_addr = '0; cfg_data = '0;
  endtask

  task automatic test_reset();
    model_reset();
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if ({obs_f(), coef_o} !== {6'b000110, {NT*CW{1'b0}}}) begin
        errors++;
        $display("FAIL reset_vals flags got=%b want=000110 coef got=%h", obs_f(), coef_o);
      end
      advance();
    end
    rst_n = 1'b1;
    settle();
    checks++;
    if ({obs_f(), coef_o} !== {exp_f, exp_coef}) begin
      errors++;
      $display("FAIL after_reset flags got=%b want=%b", obs_f(), exp_f);
    end
    advance();
  endtask

  task automatic test_commit_basic();
    for (int k = 0; k < NT; k++) gold1[k*CW +: CW] = 16'(vals[k]);
    for (int k = 0; k < NT; k++) begin
      idle_inputs();
      cfg_valid = 1'b1; cfg_addr = 3'(k); cfg_data = 32'(vals[k]);
      settle();
      checks++;
      if ({obs_f(), coef_o} !== {exp_f, exp_coef}) begin
        errors++;
        $display("FAIL write_taps k=%0d flags got=%b want=%b", k, obs_f(), exp_f);
      end
      advance();
    end
    for (int i = 0; i < FC + ML + 6; i++) begin
      idle_inputs();
      cfg_commit = (i == 0);
      settle();
      checks++;
      if ({obs_f(), coef_o} !== {exp_f, exp_coef}) begin
        errors++;
        $display("FAIL commit_seq i=%0d flags got=%b want=%b coef got=%h want=%h", i, obs_f(), exp_f, coef_o, exp_coef);
      end
      if (i == 1) begin
        checks++;
        if (coef_o !== '0) begin
          errors++;
          $display("FAIL coef_early got=%h want=0", coef_o);
        end
      end
      if (i == 2) begin
        checks++;
        if (coef_o !== gold1) begin
          errors++;
          $display("FAIL coef_at_t2 got=%h want=%h", coef_o, gold1);
        end
      end
      if (i == RESUME - 1 || i == RESUME) begin
        checks++;
        if (busy !== (i == RESUME - 1)) begin
          errors++;
          $display("FAIL busy_resume i=%0d got=%b want=%b", i, busy, (i == RESUME - 1));
        end
      end
      advance();
    end
  endtask

  task automatic test_midstream();
    gold2 = gold1;
    gold2[CW-1:0] = 16'd1234;
    for (int j = 0; j < 12; j++) begin
      idle_inputs();
      smp_valid_in = 1'b1;
      cfg_valid = (j == 0); cfg_addr = 3'd0; cfg_data = 32'd1234;
      cfg_commit = (j == 1);
      settle();
      checks++;
      if ({obs_f(), coef_o} !== {exp_f, exp_coef} || coef_o !== gold1) begin
        errors++;
        $display("FAIL midstream_hold j=%0d flags got=%b want=%b coef got=%h want=%h", j, obs_f(), exp_f, coef_o, gold1);
      end
      advance();
    end
    idle_inputs();
    settle();
    checks++;
    if ({obs_f(), coef_o} !== {exp_f, exp_coef}) begin
      errors++;
      $display("FAIL midstream_gap flags got=%b want=%b", obs_f(), exp_f);
    end
    advance();
    settle();
    checks++;
    if (coef_o !== gold2) begin
      errors++;
      $display("FAIL midstream_swap got=%h want=%h", coef_o, gold2);
    end
    advance();
    for (int j = 0; j < 30; j++) begin
      smp_valid_in = ($urandom_range(0, 3) != 0);
      settle();
      checks++;
      if ({obs_f(), coef_o} !== {exp_f, exp_coef}) begin
        errors++;
        $display("FAIL midstream_run j=%0d flags got=%b want=%b", j, obs_f(), exp_f);
      end
      advance();
    end
  endtask

  task automatic test_bad_addr();
    idle_inputs();
    cfg_valid = 1'b1; cfg_addr = 3'd7; cfg_data = 32'd555;
    settle();
    advance();
    for (int i = 0; i < RESUME + 4; i++) begin
      idle_inputs();
      cfg_commit = (i == 1);
      settle();
      checks++;
      if ({obs_f(), coef_o} !== {exp_f, exp_coef} || cfg_err !== 1'b1) begin
        errors++;
        $display("FAIL bad_addr i=%0d flags got=%b want=%b err=%b", i, obs_f(), exp_f, cfg_err);
      end
      advance();
    end
    settle();
    checks++;
    if (coef_o !== gold2) begin
      errors++;
      $display("FAIL bad_addr_bank got=%h want=%h", coef_o, gold2);
    end
    advance();
  endtask

  task automatic test_write_commit_same();
    for (int i = 0; i < RESUME + 3; i++) begin
      idle_inputs();
      if (i == 0) begin
        cfg_valid = 1'b1; cfg_addr = 3'd2; cfg_data = 32'hFFFF_FFF9; cfg_commit = 1'b1;
      end
      settle();
      checks++;
      if ({obs_f(), coef_o} !== {exp_f, exp_coef}) begin
        errors++;
        $display("FAIL wr_commit i=%0d flags got=%b want=%b coef got=%h want=%h", i, obs_f(), exp_f, coef_o, exp_coef);
      end
      advance();
    end
    settle();
    checks++;
    if (coef_o[2*CW +: CW] !== 16'hFFF9) begin
      errors++;
      $display("FAIL wr_commit_tap2 got=%h want=fff9", coef_o[2*CW +: CW]);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      smp_valid_in = ($urandom_range(0, 3) != 0);
      cfg_valid    = ($urandom_range(0, 7) == 0);
      cfg_addr     = 3'($urandom_range(0, 7));
      cfg_data     = $urandom;
      cfg_commit   = ($urandom_range(0, 40) == 0);
      settle();
      checks++;
      if ({obs_f(), coef_o} !== {exp_f, exp_coef}) begin
        errors++;
        $display("FAIL random i=%0d flags got=%b want=%b coef got=%h want=%h", i, obs_f(), exp_f, coef_o, exp_coef);
      end
      advance();
    end
  endtask

  task automatic test_reset_flush();
    for (int i = 0; i < 25; i++) begin
      idle_inputs();
      settle();
      advance();
    end
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      cfg_commit = (i == 0);
      settle();
      checks++;
      if ({obs_f(), coef_o} !== {exp_f, exp_coef}) begin
        errors++;
        $display("FAIL pre_rst i=%0d flags got=%b want=%b", i, obs_f(), exp_f);
      end
      advance();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({obs_f(), coef_o} !== {6'b000110, {NT*CW{1'b0}}}) begin
      errors++;
      $display("FAIL rst_mid_flush flags got=%b want=000110 coef got=%h", obs_f(), coef_o);
    end
    model_reset();
    smp_valid_in = 1'b1;
    settle();
    checks++;
    if ({obs_f(), coef_o} !== {exp_f, exp_coef} || filt_ce !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold flags got=%b want=%b", obs_f(), exp_f);
    end
    advance();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      smp_valid_in = 1'b1;
      settle();
      checks++;
      if ({obs_f(), coef_o} !== {exp_f, exp_coef}) begin
        errors++;
        $display("FAIL post_rst_idle i=%0d flags got=%b want=%b", i, obs_f(), exp_f);
      end
      advance();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_commit_basic();
    test_midstream();
    test_bad_addr();
    test_write_commit_same();
    test_random();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
